// File: rtl/md_unit_if.sv
// md_unit_if -- request/result bundle for the multiply/divide unit.
//   Start  : E-stage request strobe
//   MDOp   : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   Data1  : forwarded rs operand
//   Data2  : forwarded rt operand
//   Busy   : operation in progress (D-stage stalls on Start|Busy)
//   HI, LO : architectural HI/LO registers
// master: pipeline side driving requests; slave: md_unit.
interface md_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, Data1, Data2, input Busy, HI, LO);
  modport slave  (input Start, MDOp, Data1, Data2, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit -- multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Ports:
//   Clk   : single clock, rising-edge state updates
//   Reset : asynchronous active-high reset
//   bus   : md_unit_if.slave (Start, MDOp, Data1, Data2 in; Busy, HI, LO out)
// Parameters:
//   MULT_CYCLES : Busy duration of MULT/MULTU (1..15)
//   DIV_CYCLES  : Busy duration of DIV/DIVU (1..15)
// Configuration:
//   MD_DIV_EN defined   -> DIV/DIVU implemented
//   MD_DIV_EN undefined -> divider removed, DIV/DIVU behave as reserved no-ops
// The result is computed combinationally from the captured operands and
// written to HI/LO only on the edge where the cycle counter goes 1->0.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  md_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } md_op_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]         count;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  md_op_e             op_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               busy;
  logic               accept;
  md_op_e             req_op;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
`ifdef MD_DIV_EN
  logic               div_ovf;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
`endif

  assign busy     = (count != '0);
  assign accept   = bus.Start && !busy;
  assign req_op   = md_op_e'(bus.MDOp);
  assign bus.Busy = busy;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    prod_u = {32'd0, op_a} * {32'd0, op_b};
`ifdef MD_DIV_EN
    // Most-negative / -1 overflows a 32-bit signed quotient; handled explicitly.
    div_ovf = (op_a == 32'h8000_0000) && (op_b == '1);
    quo_s   = '0;
    rem_s   = '0;
    if ((op_b != '0) && !div_ovf) begin
      quo_s = $signed(op_a) / $signed(op_b);
      rem_s = $signed(op_a) % $signed(op_b);
    end
`endif
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
`ifdef MD_DIV_EN
      OP_DIV: begin
        // Divide by zero keeps HI/LO unchanged.
        if (op_b != '0) begin
          res_lo = div_ovf ? 32'h8000_0000 : quo_s;
          res_hi = div_ovf ? '0 : rem_s;
        end
      end
      OP_DIVU: begin
        if (op_b != '0) begin
          res_lo = op_a / op_b;
          res_hi = op_a % op_b;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_q  <= OP_MULT;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      case (req_op)
        OP_MULT, OP_MULTU: begin
          op_a  <= bus.Data1;
          op_b  <= bus.Data2;
          op_q  <= req_op;
          count <= MULT_N;
        end
`ifdef MD_DIV_EN
        OP_DIV, OP_DIVU: begin
          op_a  <= bus.Data1;
          op_b  <= bus.Data2;
          op_q  <= req_op;
          count <= DIV_N;
        end
`endif
        OP_MTHI: hi_q <= bus.Data1;
        OP_MTLO: lo_q <= bus.Data1;
        default: ;
      endcase
    end else if (busy) begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- self-checking bench for md_unit.
// Directed vectors plus randomized operations, checked against a behavioural
// HI/LO model computed with 64-bit integer arithmetic.
// Ports of DUT: Clk, Reset, bus (md_unit_if).
module tb_md_unit;

  localparam int unsigned T_MULT = 5;
  localparam int unsigned T_DIV  = 10;
`ifdef MD_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic Clk;
  logic Reset;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(T_MULT), .DIV_CYCLES(T_DIV)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected busy length and final HI/LO for one accepted request.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hi, input logic [31:0] lo,
                                    output int unsigned n, output logic [31:0] nh, output logic [31:0] nl);
    int ia, ib;
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    nh = hi; nl = lo; n = 0;
    case (op)
      3'd0: begin n = T_MULT; q = sa * sb; {nh, nl} = q; end
      3'd1: begin n = T_MULT; up = ua * ub; {nh, nl} = up; end
      3'd2: if (DIV_ON) begin
        n = T_DIV;
        if (b != 0) begin q = sa / sb; r = sa - q * sb; nl = q[31:0]; nh = r[31:0]; end
      end
      3'd3: if (DIV_ON) begin
        n = T_DIV;
        if (b != 0) begin up = ua / ub; nl = up[31:0]; up = ua % ub; nh = up[31:0]; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endfunction

  // Starts and ends at a falling edge. poke keeps a Start/MTLO request asserted
  // throughout Busy, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int unsigned n;
    logic [31:0] nh, nl, oh, ol;
    oh = m_hi; ol = m_lo;
    ref_model(op, a, b, oh, ol, n, nh, nl);
    bus.Start = 1'b1; bus.MDOp = op; bus.Data1 = a; bus.Data2 = b;
    @(negedge Clk);
    bus.Start = poke && (n != 0);
    bus.MDOp  = 3'b101;
    bus.Data1 = $urandom;
    bus.Data2 = $urandom;
    for (int unsigned j = 0; j < n; j++) begin
      check($sformatf("busy_op%0d_c%0d", op, j), {31'd0, bus.Busy}, 32'd1);
      check($sformatf("hold_hi_op%0d_c%0d", op, j), bus.HI, oh);
      check($sformatf("hold_lo_op%0d_c%0d", op, j), bus.LO, ol);
      @(negedge Clk);
    end
    bus.Start = 1'b0;
    check($sformatf("idle_op%0d", op), {31'd0, bus.Busy}, 32'd0);
    check($sformatf("hi_op%0d", op), bus.HI, nh);
    check($sformatf("lo_op%0d", op), bus.LO, nl);
    m_hi = nh; m_lo = nl;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b1;
    bus.Start = 1'b0; bus.MDOp = '0; bus.Data1 = '0; bus.Data2 = '0;
    #12;
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed vectors
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_neg_hi", m_hi, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_hi", m_hi, 32'h0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, 1'b0);
    run_op(3'd1, 32'd3, 32'd4, 1'b1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
    run_op(3'd7, 32'hCAFE_F00D, 32'h1, 1'b0);
    run_op(3'd5, 32'h0000_AAAA, 32'h0, 1'b0);

    // Reset during MULT 5*5, at the second Busy cycle
    bus.Start = 1'b1; bus.MDOp = 3'd0; bus.Data1 = 32'd5; bus.Data2 = 32'd5;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    check("abort_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    // First edge after release must accept
    run_op(3'd4, 32'h0BAD_F00D, 32'h0, 1'b0);
    repeat (T_MULT + 1) @(negedge Clk);
    check("post_abort_lo", bus.LO, 32'd0);
    check("post_abort_busy", {31'd0, bus.Busy}, 32'd0);

    // Randomized back-to-back operations
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, Busy duration of MULT/MULTU in cycles (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, Busy duration of DIV/DIVU in cycles (legal range 1..15).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  E-stage request strobe, sampled on rising Clk.
REQ-006 MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-007 Data1  input  32  forwarded rs operand from the E-stage bypass mux.
REQ-008 Data2  input  32  forwarded rt operand from the E-stage bypass mux.
REQ-009 Busy  output  1  operation in progress; the D-stage stall logic uses Start|Busy.
REQ-010 HI  output  32  architectural HI register, driven directly from a flop.
REQ-011 LO  output  32  architectural LO register, driven directly from a flop.

Function
REQ-012 A request is accepted at a rising edge where Start=1 and Busy=0; a Start while Busy=1 is ignored, with no state change.
REQ-013 On acceptance of MULT, MULTU, DIV or DIVU, Data1, Data2 and MDOp are captured into internal operand registers, so later input changes have no effect.
REQ-014 On acceptance of MTHI, HI<=Data1 at that same edge; LO and Busy are unchanged.
REQ-015 On acceptance of MTLO, LO<=Data1 at that same edge; HI and Busy are unchanged.
REQ-016 Reserved MDOp values are a no-op.
REQ-017 On acceptance of MULT/MULTU, a 4-bit counter loads MULT_CYCLES; on acceptance of DIV/DIVU, it loads DIV_CYCLES.
REQ-018 Busy=1 exactly while the counter is nonzero; Busy rises at the accept edge and stays high for N cycles.
REQ-019 The counter decrements by 1 per edge; at the edge where it goes 1->0, HI/LO are written and Busy falls at that same edge.
REQ-020 HI and LO hold their old values throughout Busy; no partial result is ever visible.
REQ-021 MULT produces a 64-bit two's-complement product: {HI,LO}=signed(Data1)*signed(Data2).
REQ-022 MULTU produces a 64-bit unsigned product.
REQ-023 DIV produces LO=quotient truncated toward zero and HI=remainder with the sign of the dividend.
REQ-024 DIVU produces an unsigned quotient in LO and an unsigned remainder in HI.
REQ-025 DIV/DIVU with captured Data2=0 still runs the full DIV_CYCLES Busy period, but HI and LO are left unchanged.
REQ-026 DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000 and HI=0.
REQ-027 A new request can be accepted on the first edge where Busy=0, i.e. the cycle after Busy falls, giving back-to-back throughput.

Reset
REQ-028 While Reset=1: HI=0, LO=0, Busy=0, counter=0, operand registers=0, independent of Clk.
REQ-029 Reset asserted mid-operation aborts the operation; no result write occurs after Reset is released.
REQ-030 The first edge after Reset deasserts accepts a Start normally.

Configuration
REQ-031 Macro MD_DIV_EN defined: DIV/DIVU are implemented as specified in REQ-017..REQ-026.
REQ-032 Macro MD_DIV_EN undefined: the divider logic is removed, DIV/DIVU are treated as reserved no-ops, and Busy never rises for them.

Verification
REQ-033 MULT, Data1=0xFFFFFFFF, Data2=0x00000002 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 MULTU, same operands -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 DIV, Data1=0xFFFFFFF9 (-7), Data2=0x00000002 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; with MD_DIV_EN undefined -> Busy stays 0 and HI/LO unchanged.
REQ-036 MTHI Data1=0x12345678, then DIVU Data1=7, Data2=0 -> HI=0x12345678 immediately after the MTHI edge; DIVU gives 10 Busy cycles, after which HI/LO are unchanged.
REQ-037 MULTU 3*4 accepted, then Start MTLO 0xAAAA issued during Busy -> MTLO ignored; after 5 cycles LO=0x0000000C, HI=0.
REQ-038 MULT 5*5 accepted, then Reset pulsed at cycle 2 of Busy -> HI=LO=0 and Busy=0 immediately; no write occurs later.
